// File: rtl/jesd204b_tpl_tx_v2_if.sv
// jesd204b_tpl_tx_v2_if: converter-side and link-side signal bundle of the JESD204B TX transport layer.
interface jesd204b_tpl_tx_v2_if #(
  parameter int L = 4,
  parameter int M = 8,
  parameter int N = 11,
  parameter int CS = 2,
  parameter int NP = 16,
  parameter int S = 1
);
  localparam int MP = ((M + L - 1) / L) * L;
  localparam int F = S * NP * MP / (8 * L);
  localparam int CW = S * M * CS > 0 ? S * M * CS : 1;
  logic [S*M*N-1:0] tx_datain;
  logic [CW-1:0] tx_ctrlin;
  logic tx_valid;
  logic tx_ready;
  logic link_ready;
  logic [1:0] test_mode;
  logic [8*F*L-1:0] tx_dataout;
  logic tx_dataout_valid;
  modport master (
    output tx_datain, tx_ctrlin, tx_valid, link_ready, test_mode,
    input tx_ready, tx_dataout, tx_dataout_valid
  );
  modport slave (
    input tx_datain, tx_ctrlin, tx_valid, link_ready, test_mode,
    output tx_ready, tx_dataout, tx_dataout_valid
  );
endinterface

// File: rtl/jesd204b_tpl_tx_v2.sv
// jesd204b_tpl_tx_v2: JESD204B TX transport layer packing converter samples into lane octets, with test patterns.
// Define TPL_TAIL_PRBS_EN to fill tail bits from a PRBS-9 (x^9+x^5+1) sequence instead of zeros.
module jesd204b_tpl_tx_v2 #(
  parameter int L = 4,
  parameter int M = 8,
  parameter int N = 11,
  parameter int CS = 2,
  parameter int NP = 16,
  parameter int S = 1
) (
  input logic clk,
  input logic rst,
  jesd204b_tpl_tx_v2_if.slave bus
);
  localparam int MP = ((M + L - 1) / L) * L;
  localparam int W = MP * S / L;
  localparam int F = S * NP * MP / (8 * L);
  localparam int TW = NP - N - CS;
  localparam int CW = S * M * CS > 0 ? S * M * CS : 1;
  localparam int CSW = CS > 0 ? CS : 1;
  localparam int DW = 8 * F * L;
  localparam int SW = S * M * N;
  typedef enum logic [1:0] {NORMAL = 2'b00, RAMP = 2'b01, CHECKER = 2'b10, MIDSCALE = 2'b11} mode_e;
  if ((S * NP * MP) % (8 * L) != 0 || N + CS > NP) begin : g_bad_cfg
    $error("jesd204b_tpl_tx_v2: F not integral or N+CS > NP");
  end
  function automatic logic [N-1:0] alt(input logic msb);
    logic [N-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[i] = msb ^ ((N - 1 - i) % 2 == 1);
    return r;
  endfunction
  mode_e mode;
  logic gen;
  logic [SW-1:0] pat, s1_data_d, s1_data_q;
  logic [CW-1:0] s1_ctrl_d, s1_ctrl_q;
  logic s1_valid_d, s1_valid_q;
  logic [N-1:0] cnt_d, cnt_q;
  logic phase_d, phase_q;
  logic [NP-1:0] word;
  logic [DW-1:0] packed_w, dout_d, dout_q;
  logic dout_valid_q;
`ifdef TPL_TAIL_PRBS_EN
  logic [8:0] lfsr, lfsr_d, lfsr_q;
`endif
  assign mode = mode_e'(bus.test_mode);
  assign gen = mode != NORMAL && bus.link_ready;
  assign bus.tx_ready = bus.link_ready && mode == NORMAL && !rst;
  assign bus.tx_dataout = dout_q;
  assign bus.tx_dataout_valid = dout_valid_q;
  always_comb begin
    pat = '0;
    for (int g = 0; g < M * S; g++)
      pat[g*N +: N] = mode == RAMP ? cnt_q + N'(g % S) : mode == CHECKER ? alt(~phase_q) : N'(1) << (N - 1);
    s1_valid_d = mode == NORMAL ? bus.tx_valid && bus.tx_ready : bus.link_ready;
    s1_data_d = mode == NORMAL ? bus.tx_datain : pat;
    s1_ctrl_d = mode == NORMAL ? bus.tx_ctrlin : '0;
    cnt_d = mode != RAMP ? '0 : gen ? cnt_q + N'(S) : cnt_q;
    phase_d = mode == CHECKER && (phase_q ^ gen);
  end
  // Words past M*S belong to padding converters and stay zero, so they consume no tail bits.
  always_comb begin
    packed_w = '0;
    word = '0;
`ifdef TPL_TAIL_PRBS_EN
    lfsr = lfsr_q;
`endif
    for (int g = 0; g < M * S; g++) begin
      word = NP'(s1_data_q[g*N +: N]) << (NP - N);
      if (CS > 0) word = word | (NP'(CSW'(s1_ctrl_q >> (g * CS))) << TW);
`ifdef TPL_TAIL_PRBS_EN
      for (int t = TW - 1; t >= 0; t--) begin
        word[t] = lfsr[8];
        lfsr = {lfsr[7:0], lfsr[8] ^ lfsr[4]};
      end
`endif
      packed_w[(g / W) * W * NP + (W - 1 - g % W) * NP +: NP] = word;
    end
`ifdef TPL_TAIL_PRBS_EN
    lfsr_d = s1_valid_q ? lfsr : lfsr_q;
`endif
    dout_d = s1_valid_q ? packed_w : dout_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_data_q <= '0;
      s1_ctrl_q <= '0;
      s1_valid_q <= 1'b0;
      cnt_q <= '0;
      phase_q <= 1'b0;
      dout_q <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      s1_data_q <= s1_data_d;
      s1_ctrl_q <= s1_ctrl_d;
      s1_valid_q <= s1_valid_d;
      cnt_q <= cnt_d;
      phase_q <= phase_d;
      dout_q <= dout_d;
      dout_valid_q <= s1_valid_q;
    end
  end
`ifdef TPL_TAIL_PRBS_EN
  always_ff @(posedge clk) lfsr_q <= rst ? 9'h1FF : lfsr_d;
`endif
endmodule

// File: tb/tb_jesd204b_tpl_tx_v2.sv
// tb_jesd204b_tpl_tx_v2: directed checks of the JESD204B TX transport layer across three configurations.
module tb_jesd204b_tpl_tx_v2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
`ifdef TPL_TAIL_PRBS_EN
  localparam logic [15:0] WM = 16'hFFF8;
  localparam logic [2:0] TAIL0 = 3'b111;
`else
  localparam logic [15:0] WM = 16'hFFFF;
  localparam logic [2:0] TAIL0 = 3'b000;
`endif
  localparam logic [127:0] MASK128 = {8{WM}};
  localparam logic [63:0] MASK64 = {4{WM}};
  jesd204b_tpl_tx_v2_if b0 ();
  jesd204b_tpl_tx_v2_if #(.M(6)) b1 ();
  jesd204b_tpl_tx_v2_if #(.L(2), .M(2), .S(2)) b2 ();
  jesd204b_tpl_tx_v2 d0 (.clk(clk), .rst(rst), .bus(b0));
  jesd204b_tpl_tx_v2 #(.M(6)) d1 (.clk(clk), .rst(rst), .bus(b1));
  jesd204b_tpl_tx_v2 #(.L(2), .M(2), .S(2)) d2 (.clk(clk), .rst(rst), .bus(b2));
  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if (b0.tx_dataout !== '0 || b0.tx_dataout_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out: dout=%h valid=%b, want 0/0", b0.tx_dataout, b0.tx_dataout_valid);
    end
    checks++;
    if (b0.tx_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: got %b want 0", b0.tx_ready);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (b0.tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: got %b want 1", b0.tx_ready);
    end
  endtask
  task automatic test_single_beat;
    b0.tx_datain = '0;
    b0.tx_datain[10:0] = 11'h5A5;
    b0.tx_ctrlin = '0;
    b0.tx_ctrlin[1:0] = 2'b10;
    b0.tx_valid = 1'b1;
    @(negedge clk);
    b0.tx_valid = 1'b0;
    checks++;
    if (b0.tx_dataout_valid !== 1'b0) begin
      errors++;
      $display("FAIL beat_latency1: valid=%b want 0", b0.tx_dataout_valid);
    end
    @(negedge clk);
    checks++;
    if (b0.tx_dataout_valid !== 1'b1 || (b0.tx_dataout & MASK128) !== 128'hB4B0_0000) begin
      errors++;
      $display("FAIL beat_data: valid=%b dout=%h want 1/%h", b0.tx_dataout_valid, b0.tx_dataout, 128'hB4B0_0000);
    end
    checks++;
    if (b0.tx_dataout[18:16] !== TAIL0) begin
      errors++;
      $display("FAIL beat_tail: got %b want %b", b0.tx_dataout[18:16], TAIL0);
    end
    @(negedge clk);
    checks++;
    if (b0.tx_dataout_valid !== 1'b0 || (b0.tx_dataout & MASK128) !== 128'hB4B0_0000) begin
      errors++;
      $display("FAIL beat_hold: valid=%b dout=%h want 0/%h", b0.tx_dataout_valid, b0.tx_dataout, 128'hB4B0_0000);
    end
  endtask
  task automatic test_padding;
    b1.tx_datain = '1;
    b1.tx_ctrlin = '0;
    b1.tx_valid = 1'b1;
    @(negedge clk);
    b1.tx_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (b1.tx_dataout_valid !== 1'b1 ||
        (b1.tx_dataout & MASK128) !== 128'h0000_0000_FFE0_FFE0_FFE0_FFE0_FFE0_FFE0) begin
      errors++;
      $display("FAIL pad_m6: valid=%b dout=%h want 1/%h", b1.tx_dataout_valid, b1.tx_dataout,
               128'h0000_0000_FFE0_FFE0_FFE0_FFE0_FFE0_FFE0);
    end
  endtask
  task automatic test_multi_sample;
    b2.tx_datain = {11'd4, 11'd3, 11'd2, 11'd1};
    b2.tx_ctrlin = '0;
    b2.tx_valid = 1'b1;
    @(negedge clk);
    b2.tx_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (b2.tx_dataout_valid !== 1'b1 || (b2.tx_dataout & MASK64) !== 64'h0060_0080_0020_0040) begin
      errors++;
      $display("FAIL s2_order: valid=%b dout=%h want 1/%h", b2.tx_dataout_valid, b2.tx_dataout,
               64'h0060_0080_0020_0040);
    end
  endtask
  task automatic test_link_stall;
    b0.link_ready = 1'b0;
    b0.tx_datain = '1;
    b0.tx_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (b0.tx_ready !== 1'b0) begin
      errors++;
      $display("FAIL stall_ready: got %b want 0", b0.tx_ready);
    end
    b0.link_ready = 1'b1;
    b0.tx_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (b0.tx_dataout_valid !== 1'b0 || (b0.tx_dataout & MASK128) !== 128'hB4B0_0000) begin
      errors++;
      $display("FAIL stall_no_accept: valid=%b dout=%h want 0/%h", b0.tx_dataout_valid, b0.tx_dataout,
               128'hB4B0_0000);
    end
  endtask
  task automatic test_ramp;
    logic ready_seen;
    logic [10:0] want;
    ready_seen = 1'b0;
    b0.test_mode = 2'b01;
    b0.tx_valid = 1'b1;
    @(negedge clk);
    ready_seen = ready_seen | b0.tx_ready;
    for (int f = 0; f <= 2048; f++) begin
      @(negedge clk);
      ready_seen = ready_seen | b0.tx_ready;
      want = 11'(f % 2048);
      if (f < 5 || f >= 2047) begin
        checks++;
        if (b0.tx_dataout_valid !== 1'b1 || b0.tx_dataout[31:21] !== want || b0.tx_dataout[111:101] !== want) begin
          errors++;
          $display("FAIL ramp_f%0d: valid=%b c0=%h c7=%h want 1/%h", f, b0.tx_dataout_valid,
                   b0.tx_dataout[31:21], b0.tx_dataout[111:101], want);
        end
      end
    end
    checks++;
    if (ready_seen !== 1'b0) begin
      errors++;
      $display("FAIL ramp_ready: tx_ready seen %b want 0", ready_seen);
    end
  endtask
  task automatic test_patterns;
    b0.test_mode = 2'b10;
    @(negedge clk);
    checks++;
    if (b0.tx_dataout[31:21] !== 11'h001) begin
      errors++;
      $display("FAIL mode_switch_drain: got %h want %h", b0.tx_dataout[31:21], 11'h001);
    end
    @(negedge clk);
    checks++;
    if (b0.tx_dataout_valid !== 1'b1 || b0.tx_dataout[31:21] !== 11'h555) begin
      errors++;
      $display("FAIL checker_p0: valid=%b got %h want 1/%h", b0.tx_dataout_valid, b0.tx_dataout[31:21], 11'h555);
    end
    @(negedge clk);
    checks++;
    if (b0.tx_dataout[31:21] !== 11'h2AA || b0.tx_dataout[111:101] !== 11'h2AA) begin
      errors++;
      $display("FAIL checker_p1: c0=%h c7=%h want %h", b0.tx_dataout[31:21], b0.tx_dataout[111:101], 11'h2AA);
    end
    b0.test_mode = 2'b11;
    repeat (2) @(negedge clk);
    checks++;
    if (b0.tx_dataout[31:19] !== {11'h400, 2'b00} || b0.tx_dataout[111:101] !== 11'h400) begin
      errors++;
      $display("FAIL midscale: c0=%h c7=%h want %h", b0.tx_dataout[31:19], b0.tx_dataout[111:101], {11'h400, 2'b00});
    end
    b0.test_mode = 2'b00;
    b0.tx_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (b0.tx_dataout_valid !== 1'b0) begin
      errors++;
      $display("FAIL normal_idle: valid=%b want 0", b0.tx_dataout_valid);
    end
  endtask
  task automatic test_reset_midstream;
    b0.tx_datain = '0;
    b0.tx_ctrlin = '0;
    b0.tx_datain[10:0] = 11'h123;
    b0.tx_valid = 1'b1;
    @(negedge clk);
    b0.tx_datain[10:0] = 11'h456;
    @(negedge clk);
    b0.tx_valid = 1'b0;
    checks++;
    if (b0.tx_dataout_valid !== 1'b1 || b0.tx_dataout[31:21] !== 11'h123) begin
      errors++;
      $display("FAIL pre_reset: valid=%b got %h want 1/%h", b0.tx_dataout_valid, b0.tx_dataout[31:21], 11'h123);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (b0.tx_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_in_reset: got %b want 0", b0.tx_ready);
    end
    @(negedge clk);
    checks++;
    if (b0.tx_dataout !== '0 || b0.tx_dataout_valid !== 1'b0) begin
      errors++;
      $display("FAIL midstream_reset: dout=%h valid=%b want 0/0", b0.tx_dataout, b0.tx_dataout_valid);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (b0.tx_dataout_valid !== 1'b0) begin
      errors++;
      $display("FAIL discard_stage1: valid=%b want 0", b0.tx_dataout_valid);
    end
    b0.tx_datain[10:0] = 11'h321;
    b0.tx_ctrlin[1:0] = 2'b01;
    b0.tx_valid = 1'b1;
    @(negedge clk);
    b0.tx_valid = 1'b0;
    checks++;
    if (b0.tx_dataout_valid !== 1'b0) begin
      errors++;
      $display("FAIL resume_early: valid=%b want 0", b0.tx_dataout_valid);
    end
    @(negedge clk);
    checks++;
    if (b0.tx_dataout_valid !== 1'b1 || b0.tx_dataout[31:16] !== {11'h321, 2'b01, TAIL0}) begin
      errors++;
      $display("FAIL resume_frame: valid=%b got %h want 1/%h", b0.tx_dataout_valid, b0.tx_dataout[31:16],
               {11'h321, 2'b01, TAIL0});
    end
  endtask
  initial begin
    b0.tx_datain = '0; b0.tx_ctrlin = '0; b0.tx_valid = 1'b0; b0.link_ready = 1'b1; b0.test_mode = 2'b00;
    b1.tx_datain = '0; b1.tx_ctrlin = '0; b1.tx_valid = 1'b0; b1.link_ready = 1'b1; b1.test_mode = 2'b00;
    b2.tx_datain = '0; b2.tx_ctrlin = '0; b2.tx_valid = 1'b0; b2.link_ready = 1'b1; b2.test_mode = 2'b00;
    test_reset();
    test_single_beat();
    test_padding();
    test_multi_sample();
    test_link_stall();
    test_ramp();
    test_patterns();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
